jtag_host_ctrl: RTL and testbench

- System-side JTAG initiator. Generates TCK/TMS/TDI and samples TDO to run complete IR or DR scans against the chip TAP from a simple request/response interface.
- Used by the on-chip debug bridge and the test harness to access TAP data registers (IDCODE, config register, AXI access register) without bit-banging.
- Tracks the 16-state TAP FSM internally and always parks the TAP in Run-Test/Idle between commands.

---
 rtl/jtag_host_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_jtag_host_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_ctrl.sv
// jtag_host_ctrl: system-side JTAG initiator.
// Runs complete IR or DR scans against a chip TAP from a request/response
// interface. The host tracks the TAP position and always returns the TAP to
// Run-Test/Idle after each command. It also resynchronises the TAP with a
// TMS=1 sequence after every reset.
//
// Ports:
//   clk_i        system clock
//   trst_ni      asynchronous active-low reset
//   req_*        command: valid/ready handshake, ir, tlr, len (1..MAX_LEN), data
//   rsp_*        response: valid/ready handshake, captured data, length error
//   tck_o/tms_o/tdi_o  JTAG pins driven to the TAP
//   tdo_i        JTAG data from the TAP (two-flop synchronised)
//
// Each TCK cycle has a low phase of CLK_DIV clocks, then a high phase of
// CLK_DIV clocks. The cycle ends on the falling edge. TMS and TDI for the
// next bit are updated on that falling edge. TDO is captured on the same
// falling edge from the synchroniser output. With CLK_DIV >= 2, that output
// holds the value tdo_i had when tck_o rose.
module jtag_host_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic               clk_i,
    input  logic               trst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_ir_i,
    input  logic               req_tlr_i,
    input  logic [5:0]         req_len_i,
    input  logic [MAX_LEN-1:0] req_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               rsp_err_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       LEN_MAX  = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_INIT_TLR = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PRE      = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_POST     = 3'd4,
        ST_RESP     = 3'd5
    } state_e;

    state_e               state_r;
    logic [DIV_W-1:0]     div_r;
    logic [5:0]           bit_cnt_r;
    logic                 cmd_ir_r;
    logic                 cmd_tlr_r;
    logic [5:0]           len_r;
    logic [MAX_LEN-1:0]   data_r;
    logic [MAX_LEN-1:0]   cap_r;
    logic [1:0]           tdo_sync_r;
    logic                 tck_r;
    logic                 tms_r;
    logic                 tdi_r;
    logic                 req_ready_r;
    logic                 rsp_valid_r;
    logic [MAX_LEN-1:0]   rsp_data_r;
    logic                 rsp_err_r;

    logic                 active_s;
    logic                 tick_s;
    logic                 fall_s;
    logic [5:0]           pre_last_s;
    logic [5:0]           shamt_s;

    // Divider tick, falling-edge strobe and per-command decode.
    always_comb begin
        active_s   = 1'b0;
        tick_s     = 1'b0;
        fall_s     = 1'b0;
        pre_last_s = 6'd2;
        shamt_s    = 6'd0;
        if ((state_r == ST_INIT_TLR) || (state_r == ST_PRE) ||
            (state_r == ST_SHIFT) || (state_r == ST_POST)) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
        tick_s     = active_s && (div_r == DIV_LAST);
        fall_s     = tick_s && tck_r;
        pre_last_s = cmd_ir_r ? 6'd3 : 6'd2;
        // Captured bits enter at the MSB, so right-justify by the unused width.
        shamt_s    = LEN_MAX - len_r;
    end

    // Two-flop synchroniser for tdo_i.
    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            tdo_sync_r <= 2'b00;
        end else begin
            tdo_sync_r <= {tdo_sync_r[0], tdo_i};
        end
    end

    // Command FSM, TCK divider and registered pin/handshake outputs.
    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_r     <= ST_INIT_TLR;
            div_r       <= '0;
            bit_cnt_r   <= 6'd0;
            cmd_ir_r    <= 1'b0;
            cmd_tlr_r   <= 1'b0;
            len_r       <= 6'd0;
            data_r      <= '0;
            cap_r       <= '0;
            tck_r       <= 1'b0;
            tms_r       <= 1'b1;
            tdi_r       <= 1'b0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            if (active_s) begin
                if (tick_s) begin
                    div_r <= '0;
                    tck_r <= ~tck_r;
                end else begin
                    div_r <= div_r + DIV_W'(1);
                end
            end else begin
                div_r <= '0;
                tck_r <= 1'b0;
            end

            case (state_r)
                ST_INIT_TLR: begin
                    if (fall_s) begin
                        if (bit_cnt_r == 6'd5) begin
                            bit_cnt_r <= 6'd0;
                            cmd_tlr_r <= 1'b0;
                            if (cmd_tlr_r) begin
                                state_r     <= ST_RESP;
                                rsp_valid_r <= 1'b1;
                                rsp_err_r   <= 1'b0;
                                rsp_data_r  <= '0;
                            end else begin
                                state_r     <= ST_IDLE;
                                req_ready_r <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                            // Five cycles with TMS=1, the sixth with TMS=0.
                            tms_r     <= (bit_cnt_r < 6'd4);
                        end
                    end
                end
                ST_IDLE: begin
                    if (req_valid_i && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        cmd_ir_r    <= req_ir_i;
                        cmd_tlr_r   <= req_tlr_i;
                        len_r       <= req_len_i;
                        data_r      <= req_data_i;
                        cap_r       <= '0;
                        bit_cnt_r   <= 6'd0;
                        if (req_tlr_i) begin
                            state_r <= ST_INIT_TLR;
                            tms_r   <= 1'b1;
                        end else if ((req_len_i == 6'd0) || (req_len_i > LEN_MAX)) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_data_r  <= '0;
                        end else begin
                            state_r <= ST_PRE;
                            tms_r   <= 1'b1;
                        end
                    end
                end
                ST_PRE: begin
                    if (fall_s) begin
                        if (bit_cnt_r == pre_last_s) begin
                            state_r   <= ST_SHIFT;
                            bit_cnt_r <= 6'd0;
                            tms_r     <= (len_r == 6'd1);
                            tdi_r     <= data_r[0];
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                            // IR path needs a second TMS=1 to reach Select-IR.
                            tms_r     <= cmd_ir_r && (bit_cnt_r == 6'd0);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (fall_s) begin
                        cap_r <= {tdo_sync_r[1], cap_r[MAX_LEN-1:1]};
                        if (bit_cnt_r == (len_r - 6'd1)) begin
                            state_r   <= ST_POST;
                            bit_cnt_r <= 6'd0;
                            tms_r     <= 1'b1;
                            tdi_r     <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                            data_r    <= data_r >> 1;
                            tdi_r     <= data_r[1];
                            // The final shift bit carries TMS=1 into Exit1.
                            tms_r     <= ((bit_cnt_r + 6'd2) == len_r);
                        end
                    end
                end
                ST_POST: begin
                    if (fall_s) begin
                        if (bit_cnt_r == 6'd1) begin
                            state_r     <= ST_RESP;
                            bit_cnt_r   <= 6'd0;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_data_r  <= cap_r >> shamt_s;
                        end else begin
                            bit_cnt_r <= 6'd1;
                            tms_r     <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    // Unknown encoding: resynchronise the TAP from scratch.
                    state_r     <= ST_INIT_TLR;
                    bit_cnt_r   <= 6'd0;
                    tms_r       <= 1'b1;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_data_o  = rsp_data_r;
    assign rsp_err_o   = rsp_err_r;
    assign tck_o       = tck_r;
    assign tms_o       = tms_r;
    assign tdi_o       = tdi_r;

endmodule

// File: tb/tb_jtag_host_ctrl.sv
// Directed testbench for jtag_host_ctrl with a behavioural 16-state TAP:
// 5-bit IR (reset value 1 = IDCODE), 32-bit IDCODE DR, and a 1-bit bypass DR
// for every other IR value.
module tb_jtag_host_ctrl;
    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;

    logic        clk_i       = 1'b0;
    logic        trst_ni     = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_ir_i    = 1'b0;
    logic        req_tlr_i   = 1'b0;
    logic [5:0]  req_len_i   = 6'd0;
    logic [31:0] req_data_i  = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        tck_o;
    logic        tms_o;
    logic        tdi_o;
    logic        tdo         = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    jtag_host_ctrl #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk_i(clk_i), .trst_ni(trst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_ir_i(req_ir_i), .req_tlr_i(req_tlr_i),
        .req_len_i(req_len_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    tap_e        tap_state = SH_DR;   // arbitrary start: INIT_TLR must recover it
    logic [4:0]  tap_ir    = 5'h01;
    logic [4:0]  ir_sh     = 5'h00;
    logic [31:0] dr_sh     = 32'h0;
    logic        byp       = 1'b0;
    int          rise_cnt  = 0;
    logic [63:0] tms_hist  = 64'h0;
    logic [63:0] tdi_hist  = 64'h0;

    function automatic tap_e tap_next(input tap_e s, input logic t);
        case (s)
            TLR:     return t ? TLR    : RTI;
            RTI:     return t ? SEL_DR : RTI;
            SEL_DR:  return t ? SEL_IR : CAP_DR;
            CAP_DR:  return t ? EX1_DR : SH_DR;
            SH_DR:   return t ? EX1_DR : SH_DR;
            EX1_DR:  return t ? UPD_DR : PAU_DR;
            PAU_DR:  return t ? EX2_DR : PAU_DR;
            EX2_DR:  return t ? UPD_DR : SH_DR;
            UPD_DR:  return t ? SEL_DR : RTI;
            SEL_IR:  return t ? TLR    : CAP_IR;
            CAP_IR:  return t ? EX1_IR : SH_IR;
            SH_IR:   return t ? EX1_IR : SH_IR;
            EX1_IR:  return t ? UPD_IR : PAU_IR;
            PAU_IR:  return t ? EX2_IR : PAU_IR;
            EX2_IR:  return t ? UPD_IR : SH_IR;
            UPD_IR:  return t ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck_o) begin
        rise_cnt <= rise_cnt + 1;
        tms_hist <= {tms_hist[62:0], tms_o};
        tdi_hist <= {tdi_hist[62:0], tdi_o};
        case (tap_state)
            TLR:     tap_ir <= 5'h01;
            CAP_DR:  begin dr_sh <= 32'h10000db3; byp <= 1'b0; end
            SH_DR:   begin dr_sh <= {tdi_o, dr_sh[31:1]}; byp <= tdi_o; end
            CAP_IR:  ir_sh <= 5'h01;
            SH_IR:   ir_sh <= {tdi_o, ir_sh[4:1]};
            UPD_IR:  tap_ir <= ir_sh;
            default: ;
        endcase
        tap_state <= tap_next(tap_state, tms_o);
    end

    always @(negedge tck_o) begin
        if (tap_state == SH_DR)      tdo <= (tap_ir == 5'h01) ? dr_sh[0] : byp;
        else if (tap_state == SH_IR) tdo <= ir_sh[0];
        else                         tdo <= 1'b0;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, 64'({tck_o, tms_o, tdi_o, req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o}),
            64'({6'b010000, 32'h0}));
    endtask

    // Release reset and wait for the init sequence to finish.
    task automatic release_and_init(output int clks, output int rises);
        int st;
        @(negedge clk_i);
        trst_ni = 1'b1;
        st   = rise_cnt;
        clks = 0;
        while (!req_ready_o && clks < 200) begin @(posedge clk_i); #1; clks++; end
        rises = rise_cnt - st;
    endtask

    task automatic run_cmd(input logic ir, input logic tlr, input logic [5:0] len,
                           input logic [31:0] data, input int hold,
                           output logic [31:0] rdata, output logic rerr, output int rises,
                           output int lat, output logic stable);
        int n;
        int st;
        logic [34:0] snap;
        n = 0;
        while (!req_ready_o && n < 200) begin @(posedge clk_i); #1; n++; end
        chk("ready_wait", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        req_ir_i = ir; req_tlr_i = tlr; req_len_i = len; req_data_i = data;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        st = rise_cnt;
        req_valid_i = 1'b0;
        req_ir_i = ~ir; req_len_i = ~len; req_data_i = ~data;   // must be ignored
        chk("ready_busy", 64'(req_ready_o), 64'd0);
        lat = 0;
        while (!rsp_valid_o && lat < 2000) begin @(posedge clk_i); #1; lat++; end
        chk("rsp_wait", 64'(rsp_valid_o), 64'd1);
        rdata  = rsp_data_o;
        rerr   = rsp_err_o;
        rises  = rise_cnt - st;
        snap   = {rsp_valid_o, rsp_err_o, req_ready_o, rsp_data_o};
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            if ({rsp_valid_o, rsp_err_o, req_ready_o, rsp_data_o} !== snap) stable = 1'b0;
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        chk("rsp_release", 64'({rsp_valid_o, req_ready_o}), 64'(2'b01));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        stb;
        int          rises;
        int          lat;
        int          clks;
        int          st;
        int          n;

        // Reset state
        #22;
        chk_reset_outputs("reset_vals");

        // Init sequence after reset release
        release_and_init(clks, rises);
        chk("init_clks", 64'(clks), 64'd24);
        chk("init_rises", 64'(rises), 64'd6);
        chk("init_tms", tms_hist[5:0], 64'(6'b111110));
        chk("init_tap_rti", 64'(tap_state), 64'(RTI));
        repeat (3) @(posedge clk_i);
        #1 chk("idle_tck_low", 64'(tck_o), 64'd0);

        // IDCODE read, full-length DR scan
        run_cmd(1'b0, 1'b0, 6'd32, 32'h0, 0, rd, er, rises, lat, stb);
        chk("idcode_data", 64'(rd), 64'h10000db3);
        chk("idcode_err", 64'(er), 64'd0);
        chk("idcode_rises", 64'(rises), 64'd37);
        chk("idcode_tap_rti", 64'(tap_state), 64'(RTI));

        // IR scan len=5 data=4
        run_cmd(1'b1, 1'b0, 6'd5, 32'h04, 0, rd, er, rises, lat, stb);
        chk("ir_rises", 64'(rises), 64'd11);
        chk("ir_tms", tms_hist[10:0], 64'(11'b11000000110));
        chk("ir_tdi", tdi_hist[6:2], 64'(5'b00100));
        chk("ir_capture", 64'(rd), 64'h1);
        chk("ir_tap_ir", 64'(tap_ir), 64'h4);
        chk("ir_tap_rti", 64'(tap_state), 64'(RTI));

        // Bypass (1-bit loopback) DR scan len=8 data=A5
        run_cmd(1'b0, 1'b0, 6'd8, 32'hA5, 0, rd, er, rises, lat, stb);
        chk("byp_data", 64'(rd), 64'h4A);
        chk("byp_rises", 64'(rises), 64'd13);
        chk("byp_tms", tms_hist[12:0], 64'(13'b1000000000110));
        chk("byp_tms_shift", tms_hist[9:2], 64'(8'b00000001));

        // Illegal lengths, response held 10 clk
        run_cmd(1'b0, 1'b0, 6'd0, 32'hFFFF_FFFF, 10, rd, er, rises, lat, stb);
        chk("len0_lat", 64'(lat <= 1), 64'd1);
        chk("len0_err", 64'(er), 64'd1);
        chk("len0_data", 64'(rd), 64'h0);
        chk("len0_rises", 64'(rises), 64'd0);
        chk("len0_stable", 64'(stb), 64'd1);
        run_cmd(1'b1, 1'b0, 6'd33, 32'h1234_5678, 10, rd, er, rises, lat, stb);
        chk("len33_lat", 64'(lat <= 1), 64'd1);
        chk("len33_err", 64'(er), 64'd1);
        chk("len33_data", 64'(rd), 64'h0);
        chk("len33_rises", 64'(rises), 64'd0);
        chk("len33_stable", 64'(stb), 64'd1);

        // Single-bit DR scan through bypass: one rise of TMS=1 in shift
        run_cmd(1'b0, 1'b0, 6'd1, 32'h1, 0, rd, er, rises, lat, stb);
        chk("len1_rises", 64'(rises), 64'd6);
        chk("len1_tms", tms_hist[5:0], 64'(6'b100110));
        chk("len1_data", 64'(rd), 64'h0);

        // TAP reset command
        run_cmd(1'b0, 1'b1, 6'd7, 32'hDEAD_BEEF, 0, rd, er, rises, lat, stb);
        chk("tlr_rises", 64'(rises), 64'd6);
        chk("tlr_tms", tms_hist[5:0], 64'(6'b111110));
        chk("tlr_rsp", 64'({er, rd}), 64'h0);
        chk("tlr_tap_ir", 64'(tap_ir), 64'h1);
        chk("tlr_tap_rti", 64'(tap_state), 64'(RTI));

        // Reset during the 10th shift bit of a 32-bit DR scan
        n = 0;
        while (!req_ready_o && n < 200) begin @(posedge clk_i); #1; n++; end
        @(negedge clk_i);
        req_ir_i = 1'b0; req_tlr_i = 1'b0; req_len_i = 6'd32; req_data_i = 32'h0;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        st = rise_cnt;
        n  = 0;
        while ((rise_cnt - st) < 13 && n < 500) begin @(posedge clk_i); #1; n++; end
        chk("abort_reach", 64'(rise_cnt - st), 64'd13);
        trst_ni = 1'b0;
        #1 chk_reset_outputs("abort_reset_vals");
        repeat (3) @(posedge clk_i);
        #1 chk("abort_no_rsp", 64'(rsp_valid_o), 64'd0);
        release_and_init(clks, rises);
        chk("reinit_clks", 64'(clks), 64'd24);
        chk("reinit_rises", 64'(rises), 64'd6);
        chk("reinit_tms", tms_hist[5:0], 64'(6'b111110));
        chk("reinit_tap_rti", 64'(tap_state), 64'(RTI));
        run_cmd(1'b0, 1'b0, 6'd32, 32'h0, 0, rd, er, rises, lat, stb);
        chk("reidcode_data", 64'(rd), 64'h10000db3);
        chk("reidcode_rises", 64'(rises), 64'd37);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
